// File: rtl/common_pipe_bufferf_pkg.sv
// Shared types for the flushable registered pipe buffer: state encoding and
// the per-cycle handshake summary.
package common_pipe_bufferf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  typedef struct packed {
    logic push;
    logic pop;
  } xfer_t;

  // 2'b11 is unreachable; fold it onto EMPTY so a corrupted flop self-heals.
  function automatic state_e state_decode(input logic [1:0] raw);
    case (raw)
      2'b01:   return ST_HALF;
      2'b10:   return ST_FULL;
      default: return ST_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/common_pipe_bufferf_dff.sv
// Plain register cell with synchronous active-low reset.
module common_pipe_bufferf_dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/common_pipe_bufferf_dffe.sv
// Load-enable register cell with synchronous active-low reset.
module common_pipe_bufferf_dffe #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/common_pipe_bufferf.sv
// Two-entry fully registered pipe buffer with flush: every output comes
// straight from a flop, so neither valid nor ready paths cross the stage.
module common_pipe_bufferf
  import common_pipe_bufferf_pkg::*;
#(
  parameter int BUFFER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [BUFFER_WIDTH-1:0] prev_i_data,
  input  logic                    prev_i_valid,
  output logic                    prev_o_ready,
  output logic [BUFFER_WIDTH-1:0] next_o_data,
  output logic                    next_o_valid,
  input  logic                    next_i_ready
);

  logic [1:0]              state_raw;
  logic [1:0]              state_d;
  state_e                  state;
  state_e                  state_nxt;
  logic                    flush_q;
  logic [BUFFER_WIDTH-1:0] out_q;
  logic [BUFFER_WIDTH-1:0] out_d;
  logic [BUFFER_WIDTH-1:0] skid_q;
  logic                    out_en;
  logic                    skid_en;
  xfer_t                   xfer;

  assign state        = state_decode(state_raw);
  // flush_q holds ready low one extra cycle so a stale upstream valid
  // from the flush cycle is never captured.
  assign prev_o_ready = (state != ST_FULL) & ~flush_q;
  assign next_o_valid = (state != ST_EMPTY);
  assign next_o_data  = out_q;

  assign xfer = '{push: prev_i_valid & prev_o_ready & ~flush,
                  pop:  next_o_valid & next_i_ready & ~flush};

  always_comb begin
    state_nxt = state;
    out_en    = 1'b0;
    skid_en   = 1'b0;
    out_d     = prev_i_data;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer.push) begin
            state_nxt = ST_HALF;
            out_en    = 1'b1;
          end
        end
        ST_HALF: begin
          case ({xfer.push, xfer.pop})
            2'b11: out_en = 1'b1;
            2'b10: begin
              state_nxt = ST_FULL;
              skid_en   = 1'b1;
            end
            2'b01:   state_nxt = ST_EMPTY;
            default: state_nxt = ST_HALF;
          endcase
        end
        ST_FULL: begin
          // Skid entry is always older than anything upstream; promote it.
          if (xfer.pop) begin
            state_nxt = ST_HALF;
            out_en    = 1'b1;
            out_d     = skid_q;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign state_d = state_nxt;

  common_pipe_bufferf_dff #(.WIDTH(2), .RST_VAL(2'b00)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (state_d),
    .q     (state_raw)
  );

  common_pipe_bufferf_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_flush (
    .clk   (clk),
    .reset (reset),
    .d     (flush),
    .q     (flush_q)
  );

  common_pipe_bufferf_dffe #(.WIDTH(BUFFER_WIDTH), .RST_VAL('0)) u_out (
    .clk   (clk),
    .reset (reset),
    .en    (out_en),
    .d     (out_d),
    .q     (out_q)
  );

  common_pipe_bufferf_dffe #(.WIDTH(BUFFER_WIDTH), .RST_VAL('0)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (prev_i_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_common_pipe_bufferf.sv
// Bench for common_pipe_bufferf: a two-deep FIFO model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_common_pipe_bufferf;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] prev_i_data;
  logic       prev_i_valid;
  logic       prev_o_ready;
  logic [7:0] next_o_data;
  logic       next_o_valid;
  logic       next_i_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  common_pipe_bufferf #(.BUFFER_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .prev_i_data  (prev_i_data),
    .prev_i_valid (prev_i_valid),
    .prev_o_ready (prev_o_ready),
    .next_o_data  (next_o_data),
    .next_o_valid (next_o_valid),
    .next_i_ready (next_i_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of capacity two; ready is "not full and no
  // flush last cycle", valid is "not empty", data is the head.
  logic [7:0] mq[$];
  bit         m_flush_d = 1'b0;
  bit         m_zero    = 1'b0;
  bit         started   = 1'b0;
  int         m_pops    = 0;
  int         d_pops    = 0;

  function automatic bit m_ready();
    return (mq.size() < 2) && !m_flush_d;
  endfunction

  always @(posedge clk) begin
    bit do_push, do_pop;
    started = 1'b1;
    if (reset && !flush && next_o_valid && next_i_ready) d_pops++;
    if (!reset) begin
      mq.delete();
      m_flush_d = 1'b0;
      m_zero    = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_flush_d = 1'b1;
    end else begin
      do_pop  = (mq.size() > 0) && next_i_ready;
      do_push = prev_i_valid && m_ready();
      if (do_pop) begin
        void'(mq.pop_front());
        m_pops++;
      end
      if (do_push) begin
        mq.push_back(prev_i_data);
        m_zero = 1'b0;
      end
      m_flush_d = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_ready", 32'(prev_o_ready), 32'(m_ready()));
      chk("model_valid", 32'(next_o_valid), 32'(mq.size() > 0));
      if (mq.size() > 0)
        chk("model_data", 32'(next_o_data), 32'(mq[0]));
      else if (m_zero)
        chk("model_zero_data", 32'(next_o_data), 32'h0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b0;
    flush        = 1'b0;
    prev_i_valid = 1'b1;
    prev_i_data  = 8'hA5;
    next_i_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(next_o_valid), 32'h0);
    chk("rst_data",  32'(next_o_data),  32'h0);
    chk("rst_ready", 32'(prev_o_ready), 32'h1);
    reset = 1'b1;
    step();
    chk("first_cap_valid", 32'(next_o_valid), 32'h1);
    chk("first_cap_data",  32'(next_o_data),  32'hA5);
    prev_i_valid = 1'b0;
    next_i_ready = 1'b1;
    step();

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      prev_i_valid = 1'b1;
      prev_i_data  = 8'(i);
      step();
      chk("stream_data",  32'(next_o_data),  32'(i));
      chk("stream_valid", 32'(next_o_valid), 32'h1);
      chk("stream_ready", 32'(prev_o_ready), 32'h1);
    end
    prev_i_valid = 1'b0;
    step();

    // Stall into FULL, then drain in order
    next_i_ready = 1'b0;
    prev_i_valid = 1'b1;
    prev_i_data  = 8'h20;
    step();
    prev_i_data = 8'h21;
    step();
    prev_i_data = 8'h22;
    step();
    chk("full_ready", 32'(prev_o_ready), 32'h0);
    chk("full_data",  32'(next_o_data),  32'h20);
    step();
    chk("full_hold_data", 32'(next_o_data), 32'h20);
    next_i_ready = 1'b1;
    step();
    chk("drain_skid", 32'(next_o_data),  32'h21);
    chk("drain_rdy",  32'(prev_o_ready), 32'h1);
    step();
    chk("drain_new",  32'(next_o_data), 32'h22);
    prev_i_valid = 1'b0;
    step();
    chk("drain_empty", 32'(next_o_valid), 32'h0);

    // Flush while FULL
    next_i_ready = 1'b0;
    prev_i_valid = 1'b1;
    prev_i_data  = 8'h30;
    step();
    prev_i_data = 8'h31;
    step();
    flush        = 1'b1;
    prev_i_data  = 8'h32;
    next_i_ready = 1'b1;
    step();
    chk("flush_valid", 32'(next_o_valid), 32'h0);
    chk("flush_ready", 32'(prev_o_ready), 32'h0);
    flush       = 1'b0;
    prev_i_data = 8'h33;
    step();
    chk("post_flush_ready", 32'(prev_o_ready), 32'h1);
    chk("post_flush_valid", 32'(next_o_valid), 32'h0);
    prev_i_data = 8'h34;
    step();
    chk("post_flush_data", 32'(next_o_data), 32'h34);
    prev_i_valid = 1'b0;
    step();

    // Back-to-back flush
    flush = 1'b1;
    prev_i_valid = 1'b1;
    step();
    chk("b2b_ready1", 32'(prev_o_ready), 32'h0);
    step();
    chk("b2b_ready2", 32'(prev_o_ready), 32'h0);
    flush = 1'b0;
    prev_i_valid = 1'b0;
    step();
    chk("b2b_ready3", 32'(prev_o_ready), 32'h1);

    // Sustained push and pop in HALF
    next_i_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      prev_i_valid = 1'b1;
      prev_i_data  = 8'($urandom);
      step();
    end
    prev_i_valid = 1'b0;
    step();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      prev_i_valid = ($urandom_range(0, 3) != 0);
      prev_i_data  = 8'($urandom);
      next_i_ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0;

    // Reset while FULL with flush asserted: reset wins
    next_i_ready = 1'b0;
    prev_i_valid = 1'b1;
    prev_i_data  = 8'h40;
    step();
    prev_i_data = 8'h41;
    step();
    step();
    chk("pre_rst_full", 32'(prev_o_ready), 32'h0);
    reset = 1'b0;
    flush = 1'b1;
    step();
    chk("rst_win_ready", 32'(prev_o_ready), 32'h1);
    chk("rst_win_valid", 32'(next_o_valid), 32'h0);
    chk("rst_win_data",  32'(next_o_data),  32'h0);
    reset = 1'b1;
    flush = 1'b0;
    prev_i_valid = 1'b0;
    step();
    chk("rst_win_ready2", 32'(prev_o_ready), 32'h1);

    chk("pop_count", 32'(d_pops), 32'(m_pops));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
